n_bit_down_counter: RTL and testbench

Programmable N-bit down counter with a reloadable start value, enable gating, one-shot and periodic (auto-reload) modes, and a registered terminal-count pulse. It complements the team's free-running up counter: instead of counting up from zero, it counts a loaded interval down to zero and signals completion. It serves as the interval and timeout generator for downstream control blocks.

---
 rtl/n_bit_counter_pkg.sv | 9 +
 rtl/n_bit_down_counter.sv | 82 ++++++++
 tb/tb_n_bit_down_counter.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/n_bit_counter_pkg.sv
// Shared types and constants for the programmable down counter.
package n_bit_counter_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} cnt_state_t;

    localparam logic MODE_ONESHOT  = 1'b0;
    localparam logic MODE_PERIODIC = 1'b1;

endpackage

// File: rtl/n_bit_down_counter.sv
// Programmable down counter: counts a loaded interval to zero, one-shot or periodic.
//
// state | meaning
// IDLE  | stopped, count holds, waiting for start
// RUN   | counting down while en is high
// DONE  | one-shot interval finished, count parked at 0
module n_bit_down_counter
    import n_bit_counter_pkg::*;
#(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             start,
    input  logic             stop,
    input  logic             mode,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             busy,
    output logic             done
);

    cnt_state_t       state, state_nxt;
    logic [WIDTH-1:0] reload, reload_nxt;
    logic [WIDTH-1:0] count_nxt;
    logic             tc_nxt;
    logic             start_ok;

    assign start_ok = start && (state != RUN);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            count  <= '0;
            reload <= '1;
            tc     <= 1'b0;
        end else begin
            state  <= state_nxt;
            count  <= count_nxt;
            reload <= reload_nxt;
            tc     <= tc_nxt;
        end
    end

    // stop outranks load, load outranks start, start outranks the count step
    always_comb begin
        state_nxt  = state;
        count_nxt  = count;
        reload_nxt = reload;
        tc_nxt     = 1'b0;
        if (stop) begin
            state_nxt = IDLE;
        end else if (load) begin
            reload_nxt = load_val;
            count_nxt  = load_val;
            if (start_ok) begin
                state_nxt = RUN;
            end
        end else if (start_ok) begin
            count_nxt = reload;
            state_nxt = RUN;
        end else if (state == RUN && en) begin
            if (count != '0) begin
                count_nxt = count - 1'b1;
            end else begin
                tc_nxt = 1'b1;
                if (mode == MODE_PERIODIC) begin
                    count_nxt = reload;
                end else begin
                    state_nxt = DONE;
                end
            end
        end
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);

endmodule

// File: tb/tb_n_bit_down_counter.sv
// Scoreboard bench for n_bit_down_counter (WIDTH = 3).
module tb_n_bit_down_counter;

    localparam int WIDTH = 3;

    typedef struct {
        logic [WIDTH-1:0] count;
        logic             tc;
        logic             busy;
        logic             done;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             en = 1'b0, load = 1'b0, start = 1'b0, stop = 1'b0, mode = 1'b0;
    logic [WIDTH-1:0] load_val = '0;
    logic [WIDTH-1:0] count;
    logic             tc, busy, done;

    int n_checks = 0;
    int n_errors = 0;
    int tc_seen  = 0;

    exp_t sb_q[$];

    // reference model: 0 = idle, 1 = run, 2 = done
    int               m_st;
    logic [WIDTH-1:0] m_cnt, m_rld;
    logic             m_tc;

    n_bit_down_counter #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst(rst), .en(en), .load(load), .load_val(load_val),
        .start(start), .stop(stop), .mode(mode),
        .count(count), .tc(tc), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic model_reset();
        m_st  = 0;
        m_cnt = '0;
        m_rld = '1;
        m_tc  = 1'b0;
    endtask

    task automatic model_step();
        m_tc = 1'b0;
        if (stop) begin
            m_st = 0;
        end else if (load) begin
            m_rld = load_val;
            m_cnt = load_val;
            if (start && m_st != 1) m_st = 1;
        end else if (start && m_st != 1) begin
            m_cnt = m_rld;
            m_st  = 1;
        end else if (m_st == 1 && en) begin
            if (m_cnt == 0) begin
                m_tc = 1'b1;
                if (mode) m_cnt = m_rld;
                else      m_st  = 2;
            end else begin
                m_cnt = m_cnt - 1;
            end
        end
    endtask

    // drive inputs on the falling edge, compare just after the rising edge
    task automatic cycle(input logic i_en, input logic i_load, input logic [WIDTH-1:0] i_lv,
                         input logic i_start, input logic i_stop, input logic i_mode);
        exp_t e;
        @(negedge clk);
        en = i_en; load = i_load; load_val = i_lv; start = i_start; stop = i_stop; mode = i_mode;
        model_step();
        e.count = m_cnt;
        e.tc    = m_tc;
        e.busy  = (m_st == 1);
        e.done  = (m_st == 2);
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        check_eq("count", 32'(count), 32'(e.count));
        check_eq("tc",    32'(tc),    32'(e.tc));
        check_eq("busy",  32'(busy),  32'(e.busy));
        check_eq("done",  32'(done),  32'(e.done));
        if (tc) tc_seen++;
    endtask

    task automatic async_reset(input string tag);
        #2 rst = 1'b0;
        #1;
        check_eq({tag, "_count"}, 32'(count), 0);
        check_eq({tag, "_tc"},    32'(tc),    0);
        check_eq({tag, "_busy"},  32'(busy),  0);
        check_eq({tag, "_done"},  32'(done),  0);
        model_reset();
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        model_reset();
        #1;
        check_eq("rst_count", 32'(count), 0);
        check_eq("rst_busy",  32'(busy),  0);
        @(negedge clk);
        rst = 1'b1;

        // start with reset reload value
        cycle(1, 0, 0, 1, 0, 0);
        check_eq("start_after_reset", 32'(count), 7);
        cycle(1, 0, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0, 0);
        async_reset("rst_mid_run");
        cycle(0, 0, 0, 1, 0, 0);
        check_eq("start_reload_lost", 32'(count), 7);
        cycle(0, 0, 0, 0, 1, 0);

        // one-shot R = 3
        cycle(0, 1, 3, 0, 0, 0);
        cycle(1, 0, 0, 1, 0, 0);
        check_eq("os_first", 32'(count), 3);
        tc_seen = 0;
        for (int i = 0; i < 7; i++) cycle(1, 0, 0, 0, 0, 0);
        check_eq("os_tc_pulses", 32'(tc_seen), 1);
        check_eq("os_done", 32'(done), 1);
        check_eq("os_count0", 32'(count), 0);

        // periodic R = 2, 12 enabled cycles
        cycle(0, 1, 2, 1, 0, 1);
        tc_seen = 0;
        for (int i = 0; i < 12; i++) cycle(1, 0, 0, 0, 0, 1);
        check_eq("per_tc_pulses", 32'(tc_seen), 4);
        cycle(0, 0, 0, 0, 1, 1);

        // enable gating, R = 3
        cycle(0, 1, 3, 1, 0, 1);
        tc_seen = 0;
        for (int i = 0; i < 16; i++) cycle(logic'(i % 2 == 0), 0, 0, 0, 0, 1);
        check_eq("gate_tc_pulses", 32'(tc_seen), 2);
        cycle(0, 0, 0, 0, 1, 1);

        // load collides with count == 0 in RUN
        cycle(0, 1, 2, 1, 0, 1);
        cycle(1, 0, 0, 0, 0, 1);
        cycle(1, 0, 0, 0, 0, 1);
        check_eq("coll_at_zero", 32'(count), 0);
        cycle(1, 1, 5, 0, 0, 1);
        check_eq("coll_load_count", 32'(count), 5);
        check_eq("coll_load_tc", 32'(tc), 0);
        cycle(1, 0, 0, 0, 0, 1);
        check_eq("coll_resume", 32'(count), 4);

        // stop beats load: count and reload untouched
        cycle(1, 1, 6, 0, 1, 1);
        check_eq("stop_load_count", 32'(count), 4);
        check_eq("stop_load_busy", 32'(busy), 0);
        cycle(0, 0, 0, 1, 0, 1);
        check_eq("stop_load_reload", 32'(count), 5);
        cycle(0, 0, 0, 0, 1, 1);

        // R = 0 periodic: tc continuous, then reset while tc is high
        cycle(0, 1, 0, 1, 0, 1);
        tc_seen = 0;
        for (int i = 0; i < 5; i++) cycle(1, 0, 0, 0, 0, 1);
        check_eq("r0_per_tc", 32'(tc_seen), 5);
        check_eq("r0_per_tc_high", 32'(tc), 1);
        async_reset("rst_tc_high");

        // R = 0 one-shot
        cycle(0, 1, 0, 1, 0, 0);
        cycle(1, 0, 0, 0, 0, 0);
        check_eq("r0_os_done", 32'(done), 1);
        check_eq("r0_os_tc", 32'(tc), 1);
        cycle(1, 0, 0, 0, 0, 0);
        check_eq("r0_os_tc_off", 32'(tc), 0);

        // restart from DONE using the reload register
        cycle(1, 0, 0, 1, 0, 0);
        check_eq("restart_done", 32'(busy), 1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got 0 expected 1");
        $fatal(1, "bench timeout");
    end

endmodule
